// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the integer writeback path.
//   wb_src_e   : result source select carried by a writeback request
//   wb_state_e : writeback sequencer states
//   F3_*       : load funct3 encodings understood by load_align
//   wb_req_t   : request fields held while a request is in flight
package wb_pkg;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MEM = 2'd1,
    SRC_PC4 = 2'd2,
    SRC_IMM = 2'd3
  } wb_src_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Only what the load path needs after the request handshake is over.
  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] off;
  } wb_req_t;

endpackage

// File: rtl/load_align.sv
// load_align: combinational load-data aligner/extender.
//   word   in  XLEN : raw data-memory read word
//   offset in  2    : byte address [1:0]
//   funct3 in  3    : load width/sign (LB/LH/LW/LBU/LHU, others as LW)
//   result out XLEN : aligned, sign- or zero-extended value
// Halfword selection uses offset[1] only, so misaligned halfwords fold
// onto the containing aligned halfword.
import wb_pkg::*;

module load_align #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (offset)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LH:   result = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_v};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_v};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: sequences one register-file write per instruction.
//   clk, rst_n                 : core clock, async active-low reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_rd/src/funct3          : destination, source select, load type
//   req_alu_result/pc/imm      : candidate operands (alu = address for loads)
//   mem_rdata/mem_rvalid       : data-memory read response
//   write_register/rd/rdv      : register-file write port (registered)
//   wb_done                    : one-cycle completion pulse
//   busy/pending_rd            : in-flight status and its destination
// Non-load results go straight into the output registers at the accept
// edge, so the write cycle immediately follows acceptance. Loads park in
// WAIT_MEM and load the output registers at the edge that samples
// mem_rvalid.
import wb_pkg::*;

module writeback_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_rd,
  input  logic [1:0]      req_src,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_alu_result,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_imm,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid,
  output logic            write_register,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rdv,
  output logic            wb_done,
  output logic            busy,
  output logic [4:0]      pending_rd
);

  wb_state_e       state;
  wb_req_t         lat;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] direct_val;

  // Alignment uses the latched offset/funct3: the request bus is free
  // to change while we wait for memory.
  load_align #(.XLEN(XLEN)) u_load_align (
    .word   (mem_rdata),
    .offset (lat.off),
    .funct3 (lat.funct3),
    .result (load_val)
  );

  always_comb begin
    case (wb_src_e'(req_src))
      SRC_PC4: direct_val = req_pc + XLEN'(4);
      SRC_IMM: direct_val = req_imm;
      default: direct_val = req_alu_result;
    endcase
  end

  assign req_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      lat            <= '0;
      write_register <= 1'b0;
      rd             <= '0;
      rdv            <= '0;
      wb_done        <= 1'b0;
      busy           <= 1'b0;
      pending_rd     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat.rd     <= req_rd;
            lat.funct3 <= req_funct3;
            lat.off    <= req_alu_result[1:0];
            busy       <= 1'b1;
            pending_rd <= req_rd;
            if (wb_src_e'(req_src) == SRC_MEM) begin
              state <= ST_WAIT_MEM;
            end else begin
              // x0 is hardwired: sequence normally but never strobe the write.
              write_register <= (req_rd != 5'd0);
              rd             <= req_rd;
              rdv            <= direct_val;
              wb_done        <= 1'b1;
              state          <= ST_WRITE;
            end
          end
        end
        ST_WAIT_MEM: begin
          if (mem_rvalid) begin
            write_register <= (lat.rd != 5'd0);
            rd             <= lat.rd;
            rdv            <= load_val;
            wb_done        <= 1'b1;
            state          <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // rd/rdv deliberately keep their values; only the strobes drop.
          write_register <= 1'b0;
          wb_done        <= 1'b0;
          busy           <= 1'b0;
          pending_rd     <= '0;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed cases with literal
// expectations, then randomized requests against a transaction model.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rd;
  logic [1:0]  req_src;
  logic [2:0]  req_funct3;
  logic [31:0] req_alu_result, req_pc, req_imm;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        write_register;
  logic [4:0]  rd;
  logic [31:0] rdv;
  logic        wb_done;
  logic        busy;
  logic [4:0]  pending_rd;

  int total = 0;
  int bad   = 0;

  // Expected outputs for the current cycle, maintained by the driver.
  logic        e_wr = 0, e_done = 0, e_busy = 0, e_ready = 1;
  logic [4:0]  e_rd = 0, e_prd = 0;
  logic [31:0] e_rdv = 0;

  writeback_unit #(.XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_rd         (req_rd),
    .req_src        (req_src),
    .req_funct3     (req_funct3),
    .req_alu_result (req_alu_result),
    .req_pc         (req_pc),
    .req_imm        (req_imm),
    .mem_rdata      (mem_rdata),
    .mem_rvalid     (mem_rvalid),
    .write_register (write_register),
    .rd             (rd),
    .rdv            (rdv),
    .wb_done        (wb_done),
    .busy           (busy),
    .pending_rd     (pending_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Reference load semantics written as shift/mask arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
    int unsigned b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // One compare process: every output, every cycle, against the model.
  always @(negedge clk) begin
    check("req_ready", {31'd0, req_ready}, {31'd0, e_ready});
    check("write_register", {31'd0, write_register}, {31'd0, e_wr});
    check("wb_done", {31'd0, wb_done}, {31'd0, e_done});
    check("busy", {31'd0, busy}, {31'd0, e_busy});
    check("pending_rd", {27'd0, pending_rd}, {27'd0, e_prd});
    check("rd", {27'd0, rd}, {27'd0, e_rd});
    check("rdv", rdv, e_rdv);
  end

  // Request-bus noise for cycles where the unit must ignore it.
  task automatic junk_req();
    req_valid      = 1'($urandom);
    req_rd         = 5'($urandom);
    req_src        = 2'($urandom);
    req_funct3     = 3'($urandom);
    req_alu_result = $urandom;
    req_pc         = $urandom;
    req_imm        = $urandom;
  endtask

  // Issue one request from IDLE (called at posedge+1) and track it to
  // completion; returns at posedge+1 with the unit back in IDLE.
  task automatic do_req(input logic [4:0] r, input logic [1:0] s, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm,
                        input int wt, input logic [31:0] md,
                        input bit has_lit, input logic [31:0] lit);
    logic [31:0] val;
    req_valid = 1'b1; req_rd = r; req_src = s; req_funct3 = f3;
    req_alu_result = alu; req_pc = pc; req_imm = imm;
    mem_rvalid = 1'($urandom); mem_rdata = $urandom;
    @(posedge clk); #1;
    junk_req();
    mem_rvalid = 1'b0;
    if (s == 2'd1) begin
      val = ref_load(md, alu[1:0], f3);
      e_busy = 1; e_prd = r; e_ready = 0; e_wr = 0; e_done = 0;
      repeat (wt) begin
        mem_rdata = $urandom;
        @(posedge clk); #1;
        junk_req();
      end
      mem_rvalid = 1'b1; mem_rdata = md;
      @(posedge clk); #1;
      junk_req();
      mem_rvalid = 1'($urandom); mem_rdata = $urandom;
    end else begin
      case (s)
        2'd0:    val = alu;
        2'd2:    val = pc + 32'd4;
        default: val = imm;
      endcase
    end
    e_wr = (r != 5'd0); e_rd = r; e_rdv = val; e_done = 1; e_busy = 1; e_prd = r; e_ready = 0;
    if (has_lit) begin
      check("model_literal", val, lit);
      #3 check("rdv_literal", rdv, lit);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; mem_rvalid = 1'b0;
    e_wr = 0; e_done = 0; e_busy = 0; e_prd = 0; e_ready = 1;
  endtask

  initial begin
    logic [1:0] s;
    rst_n = 1'b0;
    req_valid = 0; req_rd = 0; req_src = 0; req_funct3 = 0;
    req_alu_result = 0; req_pc = 0; req_imm = 0; mem_rdata = 0; mem_rvalid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases with hand-computed results.
    do_req(5'd5, 2'd0, 3'd0, 32'hDEADBEEF, 32'h0, 32'h0, 0, 32'h0, 1, 32'hDEADBEEF);
    do_req(5'd9, 2'd1, 3'b000, 32'h00001002, 32'h0, 32'h0, 3, 32'h12F45678, 1, 32'hFFFFFFF4);
    do_req(5'd10, 2'd1, 3'b101, 32'h00002002, 32'h0, 32'h0, 1, 32'h80010000, 1, 32'h00008001);
    do_req(5'd11, 2'd1, 3'b001, 32'h00002002, 32'h0, 32'h0, 0, 32'h80010000, 1, 32'hFFFF8001);
    do_req(5'd12, 2'd1, 3'b010, 32'h00002000, 32'h0, 32'h0, 2, 32'h80010000, 1, 32'h80010000);
    do_req(5'd13, 2'd1, 3'b001, 32'h00002003, 32'h0, 32'h0, 0, 32'h80010000, 1, 32'hFFFF8001);
    do_req(5'd14, 2'd1, 3'b100, 32'h00002003, 32'h0, 32'h0, 0, 32'h9A000000, 1, 32'h0000009A);
    do_req(5'd15, 2'd1, 3'b111, 32'h00002001, 32'h0, 32'h0, 0, 32'hCAFEF00D, 1, 32'hCAFEF00D);
    do_req(5'd1, 2'd2, 3'd0, 32'h0, 32'h00000100, 32'h0, 0, 32'h0, 1, 32'h00000104);
    do_req(5'd2, 2'd2, 3'd0, 32'h0, 32'hFFFFFFFC, 32'h0, 0, 32'h0, 1, 32'h00000000);
    do_req(5'd3, 2'd3, 3'd0, 32'h0, 32'h0, 32'hABCDE000, 0, 32'h0, 1, 32'hABCDE000);
    do_req(5'd0, 2'd0, 3'd0, 32'h55AA55AA, 32'h0, 32'h0, 0, 32'h0, 1, 32'h55AA55AA);
    do_req(5'd0, 2'd1, 3'b000, 32'h00000001, 32'h0, 32'h0, 1, 32'h00008000, 1, 32'hFFFFFF80);

    // Randomized requests, with occasional idle gaps.
    for (int i = 0; i < 120; i++) begin
      s = 2'($urandom);
      do_req(($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), s, 3'($urandom),
             $urandom, $urandom, $urandom, int'($urandom_range(0, 4)), $urandom, 0, 32'h0);
      if ($urandom_range(0, 3) == 0) begin
        mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
      end
    end

    // Reset while waiting on memory; a later rvalid must not write.
    req_valid = 1'b1; req_rd = 5'd7; req_src = 2'd1; req_funct3 = 3'b000; req_alu_result = 32'h2;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_rvalid = 1'b0;
    e_busy = 1; e_prd = 5'd7; e_ready = 0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    e_wr = 0; e_done = 0; e_busy = 0; e_prd = 0; e_ready = 1; e_rd = 0; e_rdv = 0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_pending_rd", {27'd0, pending_rd}, 32'd0);
    check("rst_rdv", rdv, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h12F45678;
    repeat (3) begin
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_wr", {31'd0, write_register}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Sequencing initiator for the integer register file in the multi-cycle core. It accepts one writeback request per instruction from the control FSM and selects the result source: ALU, load data, PC+4 or immediate. For loads, it waits for the data-memory response, then aligns and extends the load data. It then drives the register file's `write_register`/`rd`/`rdv` write port for exactly one cycle and signals completion back to control.

## Interface
Parameters:
- `XLEN`, 32, datapath width (only 32 supported)

Ports (single clock; reset is asynchronous and active-low):
- `clk` in 1: core clock, all state on posedge
- `rst_n` in 1: asynchronous active-low reset
- `req_valid` in 1: writeback request present
- `req_ready` out 1: unit can accept request (high in IDLE)
- `req_rd` in 5: destination register index
- `req_src` in 2: source select; 0 ALU, 1 MEM, 2 PC4, 3 IMM
- `req_funct3` in 3: load width/sign (MEM only)
- `req_alu_result` in XLEN: ALU result; for MEM, the byte address (bits [1:0] used)
- `req_pc` in XLEN: PC of the instruction
- `req_imm` in XLEN: immediate (LUI)
- `mem_rdata` in XLEN: data-memory read word
- `mem_rvalid` in 1: `mem_rdata` valid this cycle
- `write_register` out 1: register file write enable
- `rd` out 5: register file write index
- `rdv` out XLEN: register file write data
- `wb_done` out 1: one-cycle completion pulse
- `busy` out 1: request in flight (not IDLE)
- `pending_rd` out 5: destination index of in-flight request, 0 when idle

## Operation
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`, latch `req_rd`, `req_src`, `req_funct3`, `req_alu_result[1:0]`, and the selected operand.
    - If `req_src`=MEM, go to WAIT_MEM.
    - Otherwise, go to WRITE.
  - WAIT_MEM: hold until `mem_rvalid`=1. Capture the aligned `mem_rdata`, then go to WRITE.
  - WRITE: drive the write for one cycle, pulse `wb_done`, then go to IDLE.
- Source values:
  - ALU: `req_alu_result`
  - PC4: `req_pc`+4, mod 2^32 (0xFFFFFFFC gives 0)
  - IMM: `req_imm`
- Load alignment, with offset `off` = address[1:0]:
  - 000 LB: byte `off`, sign-extended
  - 001 LH: halfword `off[1]`, sign-extended
  - 010 LW: full word
  - 100 LBU: byte `off`, zero-extended
  - 101 LHU: halfword `off[1]`, zero-extended
  - Other encodings: treated as LW
  - Misaligned halfword (`off`=1 or 3): `off[0]` is ignored
- `rd`=0: the FSM runs normally and `wb_done` still pulses, but `write_register` stays 0.
- `mem_rvalid` is ignored outside WAIT_MEM.
- `req_valid` is ignored outside IDLE; no queueing.

## Timing
- Reset: state IDLE. Reset values:
  - `write_register`=0, `rd`=0, `rdv`=0, `wb_done`=0, `busy`=0, `pending_rd`=0
  - `req_ready`=1 (combinational from IDLE)
- Non-load requests: accepted at edge N; `write_register`/`wb_done` high for the cycle after edge N, exactly one cycle; `req_ready` high again after edge N+1.
- Load requests: `mem_rvalid` sampled at edge M; write cycle follows edge M. This holds even when `mem_rvalid` is high in the cycle immediately after acceptance.
- Outputs:
  - `write_register`, `rd` and `rdv` are registered and stable for the whole write cycle, so the register file's negedge write samples settled values.
  - `rd`/`rdv` hold their last values after the write; only `write_register` deasserts.
- `busy`=1 and `pending_rd`=latched rd from the accept edge through the end of the write cycle.
- Throughput: one request per 2 cycles minimum.
- Reset mid-operation: immediate return to IDLE with reset values; no write occurs; a later `mem_rvalid` is ignored.

## Structure
- `wb_pkg` holds:
  - `wb_src_e` (ALU/MEM/PC4/IMM)
  - `wb_state_e` (IDLE/WAIT_MEM/WRITE)
  - load funct3 constants: `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`
- One combinational sub-module, `load_align`: inputs word, offset[1:0], funct3; output the extended XLEN value. Unit-testable on its own.

## Test plan
- ALU write: rd=5, alu=0xDEADBEEF → next cycle `write_register`=1, `rd`=5, `rdv`=0xDEADBEEF, `wb_done`=1, for exactly one cycle.
- LB sign: funct3=000, addr=0x...2, `mem_rvalid` after 3 wait cycles with `mem_rdata`=0x12F45678. Required: `busy`=1 and `req_ready`=0 while waiting; `rdv`=0xFFFFFFF4 in the cycle after rvalid.
- LHU/LH: addr off=2, `mem_rdata`=0x80010000 → LHU gives `rdv`=0x00008001; LH gives 0xFFFF8001. LW gives 0x80010000.
- PC4/IMM: pc=0x00000100 gives `rdv`=0x00000104; pc=0xFFFFFFFC gives 0x00000000; imm=0xABCDE000 gives 0xABCDE000.
- rd=0 with ALU source → `wb_done` pulses, `write_register` stays 0 throughout.
- Reset asserted during WAIT_MEM, then `mem_rvalid`=1 after release → all outputs at reset values, no write, `req_ready`=1.
